bp_resolve_receiver: RTL

BP_RESOLVE_RECEIVER -- requirements
Module: bp_resolve_receiver

---
 rtl/bp_resolve_receiver_pkg.sv | 34 +++
 rtl/bp_upd_fifo.sv | 65 ++++++
 rtl/bp_resolve_receiver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bp_resolve_receiver_pkg.sv
// Shared types for the branch-resolve receiver: control-flow kinds, FSM
// states and the predictor-update queue entry.
package bp_resolve_receiver_pkg;

  // Widest virtual address carried in a queue entry; narrower VLEN builds
  // zero-extend into these fields.
  localparam int unsigned BP_ADDR_W = 64;

  typedef enum logic [2:0] {
    CF_NOCF   = 3'd0,
    CF_BRANCH = 3'd1,
    CF_JUMP   = 3'd2,
    CF_JUMPR  = 3'd3,
    CF_RETURN = 3'd4
  } cf_type_e;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  typedef struct packed {
    logic                 is_btb;
    logic [BP_ADDR_W-1:0] pc;
    logic [BP_ADDR_W-1:0] target;
    logic                 taken;
  } upd_entry_t;

  // Only conditional branches (BHT) and indirect jumps (BTB) train the predictor.
  function automatic logic cf_trains_predictor(input cf_type_e cf);
    return (cf == CF_BRANCH) || (cf == CF_JUMPR);
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Predictor-update FIFO: power-of-two depth, generic entry type, occupancy
// counter so full/empty are simple compares.
module bp_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_resolve_receiver.sv
// Branch-resolve receiver: turns branch-unit resolutions into fetch
// redirects and predictor (BHT/BTB) training updates, and counts mispredicts.
// Optional feature macro: BP_RESOLVE_CHERI_EN (capability-width targets with
// PCC metadata tracking).
module bp_resolve_receiver
  import bp_resolve_receiver_pkg::*;
#(
  parameter int unsigned VLEN   = 64,
  parameter int unsigned CLEN   = 128,
  parameter int unsigned QDEPTH = 4,
`ifdef BP_RESOLVE_CHERI_EN
  localparam int unsigned TW    = CLEN
`else
  localparam int unsigned TW    = VLEN
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            resolve_valid_i,
  output logic            resolve_ready_o,
  input  logic [VLEN-1:0] resolve_pc_i,
  input  logic [TW-1:0]   resolve_target_i,
  input  logic            resolve_taken_i,
  input  logic            resolve_mispredict_i,
  input  logic [2:0]      resolve_cf_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [TW-1:0]   redirect_target_o,
  output logic            upd_valid_o,
  input  logic            upd_ready_i,
  output logic            upd_is_btb_o,
  output logic [VLEN-1:0] upd_pc_o,
  output logic [VLEN-1:0] upd_target_o,
  output logic            upd_taken_o,
  output logic [31:0]     mispredict_cnt_o
);

  if ((CLEN < VLEN) || (QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0) ||
      (VLEN > BP_ADDR_W)) begin : g_param_check
    $error("bp_resolve_receiver: illegal VLEN/CLEN/QDEPTH combination");
  end

  state_e        state_q, state_d;
  logic [TW-1:0] target_q, target_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          accept;
  logic          mispredict;
  logic          push;
  logic          pop;
  logic          fifo_full, fifo_empty;
  upd_entry_t    entry;
  upd_entry_t    head;
  cf_type_e      cf;

  assign cf     = cf_type_e'(resolve_cf_i);
  assign accept = resolve_valid_i && resolve_ready_o;

`ifdef BP_RESOLVE_CHERI_EN
  logic [CLEN-VLEN-1:0] meta_q, meta_d;
  logic                 meta_mismatch;

  // A taken resolution carrying different PCC metadata must refetch even if
  // the address prediction was right; the last taken metadata is remembered.
  always_comb begin
    meta_d        = meta_q;
    meta_mismatch = resolve_taken_i && (resolve_target_i[CLEN-1:VLEN] != meta_q);
    if (accept && resolve_taken_i) begin
      meta_d = resolve_target_i[CLEN-1:VLEN];
    end
  end

  // PCC metadata register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
    end else begin
      meta_q <= meta_d;
    end
  end

  assign mispredict = resolve_mispredict_i || meta_mismatch;
`else
  assign mispredict = resolve_mispredict_i;
`endif

  // Redirect FSM, held target and saturating mispredict counter.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (accept && mispredict && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept && mispredict && !flush_i) begin
          state_d  = ST_REDIRECT;
          target_d = resolve_target_i;
        end
      end
      ST_REDIRECT: begin
        if (flush_i || redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Build the training entry for the current resolution.
  always_comb begin
    entry       = '0;
    entry.pc    = BP_ADDR_W'(resolve_pc_i);
    entry.taken = resolve_taken_i;
    if (cf == CF_JUMPR) begin
      entry.is_btb = 1'b1;
      entry.target = BP_ADDR_W'(resolve_target_i[VLEN-1:0]);
    end
  end

  assign push = accept && cf_trains_predictor(cf);
  assign pop  = upd_valid_o && upd_ready_i;

  bp_upd_fifo #(
    .DEPTH (QDEPTH),
    .T     (upd_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign resolve_ready_o   = (state_q == ST_IDLE) && !fifo_full;
  assign redirect_valid_o  = (state_q == ST_REDIRECT);
  assign redirect_target_o = target_q;
  assign mispredict_cnt_o  = cnt_q;
  assign upd_valid_o       = !fifo_empty;
  assign upd_is_btb_o      = upd_valid_o && head.is_btb;
  assign upd_pc_o          = upd_valid_o ? head.pc[VLEN-1:0] : '0;
  assign upd_target_o      = upd_valid_o ? head.target[VLEN-1:0] : '0;
  assign upd_taken_o       = upd_valid_o && head.taken;

endmodule
